// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and state encoding for the fetch PC redirect logic
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    TRAP   = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit saturating incrementer with synchronous active-high reset
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register, redirect/squash control and misaligned-target trap
module pc_redirect_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR   = TRAP_VECTOR_DEFAULT,
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             branch_taken,
  input  logic             jal,
  input  logic             jalr,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jalr_target,
  input  logic             stall,
  input  logic             trap_ack,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             trap_pending,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int unsigned SQ_W = 3;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CYCLES - 1);

  redirect_state_t state, state_next;
  logic [SQ_W-1:0] sq_cnt, sq_cnt_next;
  logic            trap_pending_next;
  logic [31:0]     pc_next;
  logic [31:0]     target;
  logic            misaligned;
  logic            redirect_req;

  // JALR has priority over JAL; its bit0 is architecturally discarded.
  assign target       = jalr ? {jalr_target[31:1], 1'b0} : branch_target;
  assign misaligned   = target[1];
  assign redirect_req = ex_valid & (branch_taken | jal | jalr) & (state == RUN);
  assign pc_plus4     = pc + 32'd4;

  // Flush depends only on EX decode and state, never on stall.
  assign flush_if_id = redirect_req | (state == SQUASH);
  assign flush_id_ex = redirect_req | (state == SQUASH);

  always_comb begin
    pc_next = pc_plus4;
    if (redirect_req) begin
      pc_next = misaligned ? TRAP_VECTOR : target;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_comb begin
    state_next        = state;
    sq_cnt_next       = sq_cnt;
    trap_pending_next = trap_pending;
    case (state)
      RUN: begin
        if (redirect_req) begin
          if (misaligned) begin
            state_next        = TRAP;
            trap_pending_next = 1'b1;
          end else if (SQUASH_CYCLES > 1) begin
            state_next  = SQUASH;
            sq_cnt_next = SQ_LOAD;
          end
        end
      end
      SQUASH: begin
        sq_cnt_next = sq_cnt - 1'b1;
        if (sq_cnt <= SQ_W'(1)) begin
          state_next  = RUN;
          sq_cnt_next = '0;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_next        = RUN;
          trap_pending_next = 1'b0;
        end
      end
      default: begin
        state_next        = RUN;
        sq_cnt_next       = '0;
        trap_pending_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      sq_cnt       <= '0;
      trap_pending <= 1'b0;
      pc           <= RESET_PC;
    end else begin
      state        <= state_next;
      sq_cnt       <= sq_cnt_next;
      trap_pending <= trap_pending_next;
      pc           <= pc_next;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_redirect_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (redirect_req),
    .count(redirect_count)
  );

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit with directed vectors
module tb_pc_redirect_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, ex_valid, branch_taken, jal, jalr, stall, trap_ack;
  logic [31:0]      branch_target, jalr_target;
  logic [31:0]      pc, pc_plus4;
  logic             flush_if_id, flush_id_ex, trap_pending;
  logic [CNT_W-1:0] redirect_count;

  typedef struct {
    int          id;
    bit          chk;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC     (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .SQUASH_CYCLES(2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .branch_taken  (branch_taken),
    .jal           (jal),
    .jalr          (jalr),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .trap_ack      (trap_ack),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .trap_pending  (trap_pending),
    .redirect_count(redirect_count)
  );

  task automatic chk(input int id, input string what, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", id, what, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk(e.id, "pc", pc, e.pc);
        chk(e.id, "pc_plus4", pc_plus4, e.pc + 32'd4);
        chk(e.id, "flush_if_id", {31'd0, flush_if_id}, {31'd0, e.flush});
        chk(e.id, "flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.flush});
        chk(e.id, "trap_pending", {31'd0, trap_pending}, {31'd0, e.trap});
        chk(e.id, "redirect_count", {30'd0, redirect_count}, {30'd0, e.cnt});
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input bit c, input logic r, input logic v, input logic bt, input logic j,
                      input logic jr, input logic [31:0] btgt, input logic [31:0] jtgt,
                      input logic st, input logic ack, input logic [31:0] e_pc,
                      input logic e_fl, input logic e_tr, input logic [1:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; branch_taken = bt; jal = j; jalr = jr;
    branch_target = btgt; jalr_target = jtgt; stall = st; trap_ack = ack;
    step_id++;
    e.id = step_id; e.chk = c; e.pc = e_pc; e.flush = e_fl; e.trap = e_tr; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] e_pc, input logic e_fl, input logic e_tr, input logic [1:0] e_cnt);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, e_pc, e_fl, e_tr, e_cnt);
  endtask

  task automatic br(input logic [31:0] tgt, input logic [31:0] e_pc, input logic e_fl,
                    input logic e_tr, input logic [1:0] e_cnt);
    step(1, 0, 1, 1, 0, 0, tgt, 32'h0, 0, 0, e_pc, e_fl, e_tr, e_cnt);
  endtask

  initial begin
    rst = 1; ex_valid = 0; branch_taken = 0; jal = 0; jalr = 0;
    branch_target = 0; jalr_target = 0; stall = 0; trap_ack = 0;

    // reset sequencing and free-running fetch
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 2'd0);
    idle(32'h0, 0, 0, 2'd0);
    idle(32'h4, 0, 0, 2'd0);
    idle(32'h8, 0, 0, 2'd0);
    idle(32'hC, 0, 0, 2'd0);

    // taken branch; second pulse during SQUASH is ignored
    br(32'h40, 32'h10, 1, 0, 2'd0);
    br(32'h80, 32'h40, 1, 0, 2'd1);

    // JAL with stall in the same cycle: redirect wins
    step(1, 0, 1, 0, 1, 0, 32'h80, 32'h0, 1, 0, 32'h44, 1, 0, 2'd1);
    idle(32'h80, 1, 0, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h84, 0, 0, 2'd2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h84, 0, 0, 2'd2);
    idle(32'h84, 0, 0, 2'd2);

    // JALR aligned (bit0 cleared), then misaligned -> trap
    step(1, 0, 1, 0, 0, 1, 32'h0, 32'h201, 0, 0, 32'h88, 1, 0, 2'd2);
    idle(32'h200, 1, 0, 2'd3);
    step(1, 0, 1, 0, 1, 1, 32'h400, 32'h202, 0, 0, 32'h204, 1, 0, 2'd3);
    br(32'h40, 32'h100, 0, 1, 2'd3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 0, 1, 2'd3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h108, 0, 0, 2'd3);

    // reset during SQUASH
    br(32'h20, 32'h10C, 1, 0, 2'd3);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0, 2'd3);

    // saturation of the 2-bit counter over five spaced redirects
    br(32'h40, 32'h0, 1, 0, 2'd0);
    idle(32'h40, 1, 0, 2'd1);
    br(32'h80, 32'h44, 1, 0, 2'd1);
    idle(32'h80, 1, 0, 2'd2);
    br(32'hC0, 32'h84, 1, 0, 2'd2);
    idle(32'hC0, 1, 0, 2'd3);
    br(32'h100, 32'hC4, 1, 0, 2'd3);
    idle(32'h100, 1, 0, 2'd3);
    br(32'h140, 32'h104, 1, 0, 2'd3);
    idle(32'h140, 1, 0, 2'd3);

    // pc+4 wraps at the top of the address space
    step(1, 0, 1, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 32'h144, 1, 0, 2'd3);
    idle(32'hFFFF_FFFC, 1, 0, 2'd3);
    // branch_taken without ex_valid is a bubble, not a redirect
    step(1, 0, 0, 1, 0, 0, 32'h40, 32'h0, 0, 0, 32'h0, 0, 0, 2'd3);
    idle(32'h4, 0, 0, 2'd3);

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
